trigger_level_hyst: RTL and testbench
=====================================

# trigger_level_hyst

Parametrised level/edge trigger for the sample-generator capture path. It watches a signed sample stream and detects a rising or falling crossing of a programmable level, with programmable hysteresis and holdoff. On each trigger it latches the current DMA master address as the capture offset and emits a one-cycle pulse. It supports single-shot and continuous re-arming and sits between the sample source and the DMA/offset logic.

## Interface
- DATA_WIDTH, 16, sample, level and hysteresis width.
- MEMORY_ADDR_LEN, 32, DMA address and offset width.
- HOLDOFF_WIDTH, 16, holdoff counter width.
- COUNT_WIDTH, 16, trigger event counter width.
- clk  in  1  single clock; all logic on its rising edge.
- rst  in  1  reset, asynchronous and active-high.
- enable  in  1  block enable; low forces IDLE.
- single_shot  in  1  1: stop after one trigger; 0: re-arm continuously.
- arm  in  1  one-cycle request to leave IDLE; ignored outside IDLE.
- edge_sel  in  1  0: rising crossing; 1: falling crossing.
- trigger_level  in  DATA_WIDTH  signed trigger level.
- hysteresis  in  DATA_WIDTH  unsigned re-arm band.
- holdoff  in  HOLDOFF_WIDTH  valid samples ignored after a trigger.
- in_data_valid  in  1  sample qualifier.
- in_data  in  DATA_WIDTH  signed sample.
- in_dma_master_address  in  MEMORY_ADDR_LEN  current DMA write address.
- out_trigger  out  1  one-cycle trigger pulse.
- out_data_offset  out  MEMORY_ADDR_LEN  address latched at the last trigger.
- trigger_count  out  COUNT_WIDTH  triggers since arm; saturating.
- state  out  2  0 IDLE, 1 ARMING, 2 ARMED, 3 HOLDOFF.

## Operation
- Config registers: level_r, hyst_r and edge_r are captured from the inputs on every entry to ARMING. Input changes at other times have no effect until the next entry to ARMING.
- Compare widths: comparisons use DATA_WIDTH+2-bit signed arithmetic, with hyst_r zero-extended. There is no wrap and no saturation.
- Rising edge (edge_r = 0):
  - re-arm condition: in_data < level_r − hyst_r.
  - fire condition: in_data ≥ level_r.
- Falling edge (edge_r = 1):
  - re-arm condition: in_data > level_r + hyst_r.
  - fire condition: in_data ≤ level_r.
- FSM transitions. Only samples with in_data_valid = 1 are evaluated.
  - IDLE → ARMING when enable && (arm || !single_shot). An arm accepted here clears trigger_count.
  - ARMING → ARMED on a valid sample meeting the re-arm condition. A sample already past the level therefore never fires without first crossing back through the band.
  - ARMED → HOLDOFF on a valid sample meeting the fire condition. On that edge:
    - out_trigger is 1 for exactly one cycle;
    - out_data_offset ← in_dma_master_address from the same cycle;
    - trigger_count increments, saturating at all-ones;
    - the holdoff counter loads holdoff.
  - HOLDOFF: the counter decrements on each valid sample. When it is 0, the next state is IDLE if single_shot = 1, otherwise ARMING. With holdoff = 0, HOLDOFF lasts one cycle.
- single_shot is sampled at HOLDOFF exit.
- enable = 0 in any state forces IDLE on the next edge. out_data_offset and trigger_count hold their values; out_trigger is 0.
- Reset values: state IDLE, out_trigger 0, out_data_offset 0, trigger_count 0, holdoff counter 0, level_r/hyst_r/edge_r 0.

## Timing
- Trigger latency: out_trigger and out_data_offset update on the clock edge after the qualifying valid sample is presented.
- Maximum rate: one trigger per holdoff+3 clocks with continuous valid (HOLDOFF, ARMING and ARMED each need at least one cycle).
- Simultaneous events:
  - enable falling in the same cycle as a fire: IDLE wins, no pulse.
  - arm while in ARMING, ARMED or HOLDOFF: ignored.
- Reset mid-operation: asynchronous assertion clears all outputs immediately. Release is synchronous to clk, and the first transition out of IDLE can occur on the first edge after release.
- No combinational path from inputs to outputs.

## Test plan
- Rising, continuous: level = 100, hyst = 10, holdoff = 0, ramp −50…200…−50 repeated twice, addresses incrementing.
  - out_trigger pulses at the first sample ≥ 100 on each up-ramp.
  - out_data_offset equals that sample's address; trigger_count = 2.
- Falling, single-shot: edge_sel = 1, level = −200, hyst = 20, arm pulse, sine ±1000.
  - Exactly one pulse, at the first sample ≤ −200 after a sample > −180.
  - state returns to 0; no further pulses until a new arm.
- Hysteresis rejection: level = 0, hyst = 10, after one trigger the data toggles between −5 and 5.
  - No further triggers.
  - A later sample of −11 re-arms; the next sample ≥ 0 fires.
- Holdoff: holdoff = 4, square wave crossing every 2 valid samples.
  - Triggers are separated by at least 4 valid samples plus the re-arm cycle.
  - in_data_valid gaps do not decrement the counter.
- Start above level: arm with in_data = 500, level = 100. No trigger until the data drops below 90 and then returns to ≥ 100.
- Disruption: enable deasserted in the cycle of a fire gives no pulse and state IDLE. rst asserted mid-ARMED clears state, offset and count asynchronously.

Source files
------------

// File: rtl/trigger_level_hyst.sv
// Level/edge trigger with hysteresis re-arm and holdoff for the capture path.
// On a qualifying crossing it latches the DMA address and pulses out_trigger.
module trigger_level_hyst #(
  parameter int DATA_WIDTH      = 16,
  parameter int MEMORY_ADDR_LEN = 32,
  parameter int HOLDOFF_WIDTH   = 16,
  parameter int COUNT_WIDTH     = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       enable,
  input  logic                       single_shot,
  input  logic                       arm,
  input  logic                       edge_sel,
  input  logic [DATA_WIDTH-1:0]      trigger_level,
  input  logic [DATA_WIDTH-1:0]      hysteresis,
  input  logic [HOLDOFF_WIDTH-1:0]   holdoff,
  input  logic                       in_data_valid,
  input  logic [DATA_WIDTH-1:0]      in_data,
  input  logic [MEMORY_ADDR_LEN-1:0] in_dma_master_address,
  output logic                       out_trigger,
  output logic [MEMORY_ADDR_LEN-1:0] out_data_offset,
  output logic [COUNT_WIDTH-1:0]     trigger_count,
  output logic [1:0]                 state
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARMING  = 2'd1,
    S_ARMED   = 2'd2,
    S_HOLDOFF = 2'd3
  } state_t;

  localparam int CW = DATA_WIDTH + 2;

  state_t                     state_q, state_d;
  logic [DATA_WIDTH-1:0]      level_q, level_d;
  logic [DATA_WIDTH-1:0]      hyst_q, hyst_d;
  logic                       edge_q, edge_d;
  logic [HOLDOFF_WIDTH-1:0]   hold_cnt_q, hold_cnt_d;
  logic                       trig_q, trig_d;
  logic [MEMORY_ADDR_LEN-1:0] offset_q, offset_d;
  logic [COUNT_WIDTH-1:0]     count_q, count_d;
  logic                       enter_arming;

  // Two guard bits: level -/+ an unsigned hysteresis can never overflow.
  logic signed [CW-1:0] data_x, level_x, hyst_x, lo_x, hi_x;
  logic                 rearm_hit, fire_hit;

  always_comb begin
    data_x    = {{2{in_data[DATA_WIDTH-1]}}, in_data};
    level_x   = {{2{level_q[DATA_WIDTH-1]}}, level_q};
    hyst_x    = {2'b00, hyst_q};
    lo_x      = level_x - hyst_x;
    hi_x      = level_x + hyst_x;
    rearm_hit = edge_q ? (data_x > hi_x) : (data_x < lo_x);
    fire_hit  = edge_q ? (data_x <= level_x) : (data_x >= level_x);
  end

  // NOTE: every signal written here gets its default first, so no path
  // through the case leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d      = state_q;
    level_d      = level_q;
    hyst_d       = hyst_q;
    edge_d       = edge_q;
    hold_cnt_d   = hold_cnt_q;
    trig_d       = 1'b0;
    offset_d     = offset_q;
    count_d      = count_q;
    enter_arming = 1'b0;

    if (!enable) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (arm || !single_shot) begin
            state_d      = S_ARMING;
            enter_arming = 1'b1;
            if (arm) count_d = '0;
          end
        end
        S_ARMING: begin
          if (in_data_valid && rearm_hit) state_d = S_ARMED;
        end
        S_ARMED: begin
          if (in_data_valid && fire_hit) begin
            state_d    = S_HOLDOFF;
            trig_d     = 1'b1;
            offset_d   = in_dma_master_address;
            hold_cnt_d = holdoff;
            if (count_q != '1) count_d = count_q + 1'b1;
          end
        end
        S_HOLDOFF: begin
          if (hold_cnt_q == '0) begin
            state_d      = single_shot ? S_IDLE : S_ARMING;
            enter_arming = !single_shot;
          end else if (in_data_valid) begin
            hold_cnt_d = hold_cnt_q - 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    // Config is frozen for the whole arm/fire/holdoff cycle.
    if (enter_arming) begin
      level_d = trigger_level;
      hyst_d  = hysteresis;
      edge_d  = edge_sel;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      level_q    <= '0;
      hyst_q     <= '0;
      edge_q     <= 1'b0;
      hold_cnt_q <= '0;
      trig_q     <= 1'b0;
      offset_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      level_q    <= level_d;
      hyst_q     <= hyst_d;
      edge_q     <= edge_d;
      hold_cnt_q <= hold_cnt_d;
      trig_q     <= trig_d;
      offset_q   <= offset_d;
      count_q    <= count_d;
    end
  end

  assign out_trigger     = trig_q;
  assign out_data_offset = offset_q;
  assign trigger_count   = count_q;
  assign state           = state_q;

endmodule

// File: tb/tb_trigger_level_hyst.sv
// Directed bench for trigger_level_hyst: hand-computed pulse positions,
// offsets, counts and states for each scenario.
module tb_trigger_level_hyst;

  logic        clk;
  logic        rst;
  logic        enable;
  logic        single_shot;
  logic        arm;
  logic        edge_sel;
  logic [15:0] trigger_level;
  logic [15:0] hysteresis;
  logic [15:0] holdoff;
  logic        in_data_valid;
  logic [15:0] in_data;
  logic [31:0] in_dma_master_address;
  logic        out_trigger;
  logic [31:0] out_data_offset;
  logic [15:0] trigger_count;
  logic [1:0]  state;

  int n_checks = 0;
  int n_errors = 0;

  trigger_level_hyst dut (
    .clk                  (clk),
    .rst                  (rst),
    .enable               (enable),
    .single_shot          (single_shot),
    .arm                  (arm),
    .edge_sel             (edge_sel),
    .trigger_level        (trigger_level),
    .hysteresis           (hysteresis),
    .holdoff              (holdoff),
    .in_data_valid        (in_data_valid),
    .in_data              (in_data),
    .in_dma_master_address(in_dma_master_address),
    .out_trigger          (out_trigger),
    .out_data_offset      (out_data_offset),
    .trigger_count        (trigger_count),
    .state                (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  task automatic step(input bit v, input int d, input logic [31:0] a);
    in_data_valid         = v;
    in_data               = 16'(d);
    in_dma_master_address = a;
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input bit e, input int lvl, input int hy, input int ho, input bit ss);
    edge_sel      = e;
    trigger_level = 16'(lvl);
    hysteresis    = 16'(hy);
    holdoff       = 16'(ho);
    single_shot   = ss;
  endtask

  task automatic arm_pulse();
    arm = 1'b1;
    @(posedge clk);
    #1;
    arm = 1'b0;
  endtask

  int ramp [11] = '{-50, 0, 50, 100, 150, 200, 150, 100, 50, 0, -50};
  int sine [8]  = '{0, 707, 1000, 707, 0, -707, -1000, -707};
  int hseq [11] = '{-20, 5, -5, 5, -5, 5, -5, 5, -11, 0, 0};
  int sq_d [12] = '{-100, -100, 100, 100, -100, -100, -100, 100, 100, -100, -100, 100};
  bit sq_v [12] = '{1, 1, 1, 1, 0, 0, 1, 1, 1, 1, 1, 1};
  int above [7] = '{500, 300, 95, 150, 89, 99, 100};

  initial begin
    rst = 1'b1; enable = 1'b0; arm = 1'b0; in_data_valid = 1'b0; in_data = '0;
    in_dma_master_address = '0;
    cfg(0, 0, 0, 0, 1);
    repeat (2) @(posedge clk);
    #1;
    check("rst_state", state, 0);
    check("rst_trig", out_trigger, 0);
    check("rst_offset", out_data_offset, 0);
    check("rst_count", trigger_count, 0);
    rst = 1'b0;

    // Rising, continuous, holdoff 0: fires at ramp value 100 on each up-ramp.
    cfg(0, 100, 10, 0, 0);
    enable = 1'b1;
    arm_pulse();
    check("t1_arming", state, 1);
    for (int i = 0; i < 22; i++) begin
      step(1, ramp[i % 11], 32'h1000 + i);
      check($sformatf("t1_trig[%0d]", i), out_trigger, (i == 3 || i == 14));
    end
    check("t1_count", trigger_count, 2);
    check("t1_offset", out_data_offset, 32'h100E);
    enable = 1'b0;
    step(0, 0, 0);
    check("t1_dis_state", state, 0);
    check("t1_dis_count", trigger_count, 2);
    check("t1_dis_offset", out_data_offset, 32'h100E);

    // Falling, single shot: one pulse at -707 after the 0 sample re-armed.
    cfg(1, -200, 20, 0, 1);
    enable = 1'b1;
    arm_pulse();
    check("t2_count_clr", trigger_count, 0);
    for (int i = 0; i < 16; i++) begin
      step(1, sine[i % 8], 32'h2000 + i);
      check($sformatf("t2_trig[%0d]", i), out_trigger, (i == 5));
    end
    check("t2_state", state, 0);
    check("t2_count", trigger_count, 1);
    check("t2_offset", out_data_offset, 32'h2005);

    // Hysteresis: +/-5 toggling never re-arms; -11 does, then 0 fires.
    cfg(0, 0, 10, 0, 0);
    arm_pulse();
    for (int i = 0; i < 11; i++) begin
      step(1, hseq[i], 32'h3000 + i);
      check($sformatf("t3_trig[%0d]", i), out_trigger, (i == 1 || i == 9));
      if (i == 7) check("t3_stuck_arming", state, 1);
    end
    check("t3_count", trigger_count, 2);
    check("t3_offset", out_data_offset, 32'h3009);

    // Holdoff 4 with valid gaps that must not decrement the counter.
    enable = 1'b0;
    step(0, 0, 0);
    cfg(0, 0, 10, 4, 0);
    enable = 1'b1;
    arm_pulse();
    for (int i = 0; i < 12; i++) begin
      step(sq_v[i], sq_d[i], 32'h4000 + i);
      check($sformatf("t4_trig[%0d]", i), out_trigger, (i == 2 || i == 11));
      if (i == 5) check("t4_gap_hold", state, 3);
      if (i == 8) check("t4_hold_end", state, 3);
      if (i == 9) check("t4_rearm", state, 1);
    end
    check("t4_offset", out_data_offset, 32'h400B);

    // Armed while above level: must dip below 90 before 100 can fire.
    enable = 1'b0;
    step(0, 0, 0);
    cfg(0, 100, 10, 0, 0);
    enable = 1'b1;
    in_data = 16'(500);
    arm_pulse();
    for (int i = 0; i < 7; i++) begin
      step(1, above[i], 32'h5000 + i);
      check($sformatf("t5_trig[%0d]", i), out_trigger, (i == 6));
      if (i == 3) check("t5_still_arming", state, 1);
      if (i == 4) check("t5_armed", state, 2);
    end
    check("t5_offset", out_data_offset, 32'h5006);

    // Enable dropped on the fire cycle: no pulse, IDLE, count held.
    enable = 1'b0;
    step(0, 0, 0);
    enable = 1'b1;
    arm_pulse();
    step(1, -50, 32'h6000);
    check("t6_armed", state, 2);
    enable = 1'b0;
    step(1, 100, 32'h6001);
    check("t6_no_trig", out_trigger, 0);
    check("t6_idle", state, 0);
    check("t6_count_hold", trigger_count, 0);
    check("t6_offset_hold", out_data_offset, 32'h5006);

    // Async reset while ARMED clears everything without a clock edge.
    enable = 1'b1;
    arm_pulse();
    step(1, -50, 32'h6002);
    step(1, 100, 32'h6003);
    check("t6_trig", out_trigger, 1);
    check("t6_count", trigger_count, 1);
    check("t6_offset", out_data_offset, 32'h6003);
    step(1, 0, 32'h6004);
    step(1, -50, 32'h6005);
    check("t6_rearmed", state, 2);
    #2;
    rst = 1'b1;
    #1;
    check("t6_rst_state", state, 0);
    check("t6_rst_offset", out_data_offset, 0);
    check("t6_rst_count", trigger_count, 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("t6_post_rst", state, 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
